// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multi-cycle MIPS main control FSM with memory-ready stalls, trap and retire counter
// Optional immediate-ALU instructions (ADDI via IMMEX/IMMWB) are built when MIPS_MC_IMM_OPS_EN is defined.
module mips_multicycle_control #(
  parameter int              OP_W     = 6,
  parameter logic [OP_W-1:0] OP_RTYPE = 6'b000000,
  parameter logic [OP_W-1:0] OP_LW    = 6'b100011,
  parameter logic [OP_W-1:0] OP_SW    = 6'b101011,
  parameter logic [OP_W-1:0] OP_BEQ   = 6'b000100,
  parameter logic [OP_W-1:0] OP_J     = 6'b000010,
  parameter logic [OP_W-1:0] OP_ADDI  = 6'b001000,
  parameter int              CNT_W    = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [OP_W-1:0]  Opcode,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             IllegalOp,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] RetiredCount
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_IMMEX  = 4'd11,
    S_IMMWB  = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  state_t            state_q, state_d;
  logic [OP_W-1:0]   opcode_q, opcode_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              retire;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    retire      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    IllegalOp   = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      // IR load and PC+4 write only happen in the cycle the instruction word arrives
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
        if (MemReady) state_d = S_FETCH == S_FETCH ? S_DECODE : S_DECODE;
      end

      S_DECODE: begin
        ALUSrcB  = 2'b11;
        opcode_d = Opcode;
        if (Opcode == OP_RTYPE)                      state_d = S_EXEC;
        else if (Opcode == OP_LW || Opcode == OP_SW) state_d = S_MEMADR;
        else if (Opcode == OP_BEQ)                   state_d = S_BRANCH;
        else if (Opcode == OP_J)                     state_d = S_JUMP;
`ifdef MIPS_MC_IMM_OPS_EN
        else if (Opcode == OP_ADDI)                  state_d = S_IMMEX;
`endif
        else                                         state_d = S_TRAP;
      end

      // From here on the latched opcode steers, the IR field may already be changing
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (opcode_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end

      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end

      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end

      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end

      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end

      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end

`ifdef MIPS_MC_IMM_OPS_EN
      S_IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_IMMWB;
      end

      S_IMMWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
`endif

      S_TRAP: begin
        IllegalOp = 1'b1;
        state_d   = S_TRAP;
      end

      default: state_d = S_TRAP;
    endcase
  end

  assign count_d      = retire ? count_q + CNT_W'(1) : count_q;
  assign State        = state_q;
  assign RetiredCount = count_q;

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multi-cycle MIPS main control FSM. Successor to the single-cycle opcode decoder; sits between the instruction register opcode field and the datapath muxes, register file, ALU control and memory.
- Sequences each instruction through FETCH/DECODE/execute states. Waits on a memory ready handshake, traps unsupported opcodes and counts retired instructions.
- Opcode width and encodings are parametrised.

Parameters:
OP_W, 6, opcode field width
OP_RTYPE, 6'b000000, R-type encoding
OP_LW, 6'b100011, load word encoding
OP_SW, 6'b101011, store word encoding
OP_BEQ, 6'b000100, branch-equal encoding
OP_J, 6'b000010, jump encoding
OP_ADDI, 6'b001000, add-immediate encoding (used only with the optional feature)
CNT_W, 16, retired-instruction counter width

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Opcode  in  OP_W  instruction opcode field from the IR
MemReady  in  1  memory access completes this cycle
PCWrite  out  1  unconditional PC write
PCWriteCond  out  1  PC write if ALU Zero
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  instruction register load
MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR
RegDst  out  1  destination register: 0 = rt, 1 = rd
RegWrite  out  1  register file write
ALUSrcA  out  1  ALU A operand: 0 = PC, 1 = rs
ALUSrcB  out  2  ALU B operand: 00 = rt, 01 = 4, 10 = signext imm, 11 = signext imm << 2
ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded
PCSource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
IllegalOp  out  1  high while in TRAP
State  out  4  current state encoding, for debug
RetiredCount  out  CNT_W  number of instructions completed

Behaviour:
- State encoding: IDLE = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4, MEMWB = 5, MEMWR = 6, EXEC = 7, ALUWB = 8, BRANCH = 9, JUMP = 10, IMMEX = 11, IMMWB = 12, TRAP = 13.
- Reset (async, any time, including mid-instruction): State = IDLE, RetiredCount = 0, internal opcode latch = 0, all outputs 0. The first rising edge after Reset falls moves IDLE to FETCH.
- Outputs are decoded from State only (Moore), with one exception: in FETCH, IRWrite and PCWrite equal MemReady (Mealy).
- The opcode latch captures Opcode on the DECODE cycle. MEMADR and later states use the latch, not the Opcode input.
- FETCH: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00. Hold while MemReady = 0; move to DECODE on MemReady = 1.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00. Next state by Opcode: RTYPE -> EXEC, LW/SW -> MEMADR, BEQ -> BRANCH, J -> JUMP, ADDI -> IMMEX (feature only), anything else -> TRAP.
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Latched LW -> MEMRD, otherwise -> MEMWR.
- MEMRD: MemRead = 1, IorD = 1. Hold until MemReady = 1, then -> MEMWB.
- MEMWB: RegWrite = 1, MemtoReg = 1, RegDst = 0; -> FETCH.
- MEMWR: MemWrite = 1, IorD = 1. Hold until MemReady = 1, then -> FETCH.
- EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10; -> ALUWB.
- ALUWB: RegWrite = 1, RegDst = 1, MemtoReg = 0; -> FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01; -> FETCH.
- JUMP: PCWrite = 1, PCSource = 10; -> FETCH.
- TRAP: IllegalOp = 1, all other controls 0. Stays in TRAP until Reset.
- Undefined State values: go to TRAP on the next edge.
- RetiredCount increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, JUMP or IMMWB. It wraps modulo 2^CNT_W. It does not increment on IDLE -> FETCH.
- Cycle counts with zero memory wait (MemReady = 1 when sampled): R-type 4, LW 5, SW 4, BEQ 3, J 3. Each cycle MemReady is low in FETCH, MEMRD or MEMWR adds one cycle.

Optional Feature:
- Macro: MIPS_MC_IMM_OPS_EN.
- Defined: OP_ADDI in DECODE -> IMMEX, then IMMWB, then FETCH.
  - IMMEX: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00.
  - IMMWB: RegWrite = 1, RegDst = 0, MemtoReg = 0.
  - ADDI takes 4 cycles and is counted as retired.
- Undefined: IMMEX and IMMWB are not implemented. OP_ADDI decodes to TRAP.

Test Plan:
- Reset high for 2 cycles, then low with MemReady = 1 -> all outputs 0 in IDLE; FETCH on the next edge; RetiredCount = 0.
- R-type 000000, MemReady = 1 -> states 1,2,7,8,1; RegWrite = 1 with RegDst = 1 only in ALUWB; RetiredCount = 1 after 4 cycles.
- LW 100011, MemReady low for 2 cycles in MEMRD -> MEMRD holds 3 cycles with MemRead = 1, IorD = 1; MEMWB has MemtoReg = 1; instruction takes 7 cycles.
- SW 101011, then BEQ 000100, then J 000010 -> MemWrite pulses 1 cycle; PCWriteCond = 1 with PCSource = 01 in BRANCH; PCWrite = 1 with PCSource = 10 in JUMP; RetiredCount = 3.
- Opcode 111111 -> TRAP, IllegalOp = 1 held 10 cycles, RetiredCount unchanged. Assert Reset -> State = 0 immediately, without waiting for a clock edge.
- Reset asserted mid-MEMRD with RetiredCount = 0xFFFF (CNT_W = 16) -> immediate IDLE, count 0. Separately, retiring from 0xFFFF -> count wraps to 0x0000.
